// File: rtl/wb_pkg.sv
// Shared writeback types: opcode / function encodings and the queued multdiv result entry.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_REG_AW = 5;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_SETX  = 5'b10101;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   typedef struct packed {
      logic [WB_REG_AW-1:0] rd;
      logic [WB_DATA_W-1:0] result;
      logic                 exception;
   } md_entry_t;

endpackage

// File: rtl/stage_write_arbiter_if.sv
// Pipeline, multdiv and regfile/rstatus write signals of the writeback stage.
// Perf counter outputs exist only when STAGE_WRITE_PERF_EN is defined.
interface stage_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic [4:0]        opcode;
   logic [4:0]        ALU_op;
   logic [REG_AW-1:0] rd;
   logic [DATA_W-1:0] o_in;
   logic [DATA_W-1:0] d_in;
   logic [DATA_W-1:0] pc_plus_4;
   logic [4:0]        pc_upper_5;
   logic [26:0]       target;
   logic              exception;

   logic              md_valid;
   logic              md_ready;
   logic [REG_AW-1:0] md_rd;
   logic [DATA_W-1:0] md_result;
   logic              md_exception;

   logic              ctrl_writeEnable;
   logic [REG_AW-1:0] ctrl_writeReg;
   logic [DATA_W-1:0] data_writeReg;
   logic              ctrl_writeStatus;
   logic [DATA_W-1:0] data_writeStatusReg;
   logic [2**REG_AW-1:0] md_pending;

`ifdef STAGE_WRITE_PERF_EN
   logic [31:0]       perf_retired;
   logic [31:0]       perf_md_stall;
`endif

   modport master (
      output in_valid, opcode, ALU_op, rd, o_in, d_in, pc_plus_4, pc_upper_5, target, exception,
      output md_valid, md_rd, md_result, md_exception,
      input  md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      input  ctrl_writeStatus, data_writeStatusReg, md_pending
`ifdef STAGE_WRITE_PERF_EN
      , input perf_retired, perf_md_stall
`endif
   );

   modport slave (
      input  in_valid, opcode, ALU_op, rd, o_in, d_in, pc_plus_4, pc_upper_5, target, exception,
      input  md_valid, md_rd, md_result, md_exception,
      output md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      output ctrl_writeStatus, data_writeStatusReg, md_pending
`ifdef STAGE_WRITE_PERF_EN
      , output perf_retired, perf_md_stall
`endif
   );

endinterface

// File: rtl/stage_write_arbiter_md_result_fifo.sv
// Multdiv result FIFO with per-entry valid bits and a registered destination-pending mask.
module md_result_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STATUS_REG = 30
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push_i,
   input  md_entry_t              push_data_i,
   input  logic                   pop_i,
   output md_entry_t              head_o,
   output logic                   empty_o,
   output logic                   ready_o,
   output logic [2**WB_REG_AW-1:0] pending_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   md_entry_t mem_q [DEPTH];
   md_entry_t mem_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count;
   logic [2**WB_REG_AW-1:0] pending_q, pending_d;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign empty_o = (count == '0);
   assign ready_o = (count < DEPTH_P);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign pending_o = pending_q;

   always_comb begin
      mem_d    = mem_q;
      vld_d    = vld_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (pop_i) begin
         vld_d[rd_ptr_q[AW-1:0]] = 1'b0;
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_i) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
         vld_d[wr_ptr_q[AW-1:0]] = 1'b1;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      // Mask follows the post-update contents so it changes on the same edge as the FIFO.
      pending_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_d[i]) begin
            pending_d[mem_d[i].rd] = 1'b1;
            if (mem_d[i].exception) pending_d[STATUS_REG] = 1'b1;
         end
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_q     <= '{default: '0};
         vld_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pending_q <= '0;
      end else begin
         mem_q     <= mem_d;
         vld_q     <= vld_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/stage_write_arbiter.sv
// Writeback stage: merges in-order pipeline results and multdiv results onto the regfile
// and rstatus write ports, pipeline first. Optional perf counters: STAGE_WRITE_PERF_EN.
module stage_write_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W     = WB_DATA_W,
   parameter int REG_AW     = WB_REG_AW,
   parameter int MD_DEPTH   = 4,
   parameter int STATUS_REG = 30,
   parameter int LINK_REG   = 31
) (
   input logic                  clock,
   input logic                  reset,
   stage_write_arbiter_if.slave bus
);
   logic rtype, is_addi, is_lw, is_jal, is_setx, is_mul, is_div, is_addsub;
   logic p_wr_raw, p_wr, p_st;
   logic [REG_AW-1:0] p_addr;
   logic [DATA_W-1:0] p_data, p_st_data;

   md_entry_t md_in, fifo_head, cand;
   logic fifo_empty, fifo_ready, push_acc, cand_valid, retire, push, pop;
   logic [2**REG_AW-1:0] fifo_pending;

   logic              we_q, we_d, st_q, st_d;
   logic [REG_AW-1:0] wreg_q, wreg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, stdata_q, stdata_d;

   always_comb begin
      rtype     = bus.in_valid & (bus.opcode == OP_RTYPE);
      is_addi   = bus.in_valid & (bus.opcode == OP_ADDI);
      is_lw     = bus.in_valid & (bus.opcode == OP_LW);
      is_jal    = bus.in_valid & (bus.opcode == OP_JAL);
      is_setx   = bus.in_valid & (bus.opcode == OP_SETX);
      is_mul    = rtype & (bus.ALU_op == ALU_MUL);
      is_div    = rtype & (bus.ALU_op == ALU_DIV);
      is_addsub = rtype & ((bus.ALU_op == ALU_ADD) | (bus.ALU_op == ALU_SUB));

      p_wr_raw = (rtype & ~is_mul & ~is_div) | is_addi | is_lw | is_jal;
      p_addr   = is_jal ? REG_AW'(LINK_REG) : bus.rd;
      p_wr     = p_wr_raw & (p_addr != '0);
      p_data   = is_jal ? bus.pc_plus_4 : (is_lw ? bus.d_in : bus.o_in);

      p_st      = ((is_addsub | is_addi) & bus.exception) | is_setx;
      p_st_data = is_setx ? DATA_W'({bus.pc_upper_5, bus.target}) : DATA_W'(1);
   end

   // Empty FIFO lets an accepted offer fall straight through as the candidate.
   always_comb begin
      md_in      = '{rd: bus.md_rd, result: bus.md_result, exception: bus.md_exception};
      push_acc   = bus.md_valid & fifo_ready;
      cand       = fifo_empty ? md_in : fifo_head;
      cand_valid = ~fifo_empty | push_acc;
      retire     = cand_valid
                 & ((cand.rd == '0) | ~p_wr)
                 & (~cand.exception | ~p_st);
      pop        = retire & ~fifo_empty;
      push       = push_acc & ~(fifo_empty & retire);

      we_d     = p_wr | (retire & (cand.rd != '0));
      wreg_d   = p_wr ? p_addr : cand.rd;
      wdata_d  = p_wr ? p_data : cand.result;
      st_d     = p_st | (retire & cand.exception);
      stdata_d = p_st ? p_st_data : DATA_W'(1);
   end

   md_result_fifo #(
      .DEPTH      (MD_DEPTH),
      .STATUS_REG (STATUS_REG)
   ) u_md_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (md_in),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .ready_o     (fifo_ready),
      .pending_o   (fifo_pending)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         we_q     <= 1'b0;
         wreg_q   <= '0;
         wdata_q  <= '0;
         st_q     <= 1'b0;
         stdata_q <= '0;
      end else begin
         we_q     <= we_d;
         wreg_q   <= wreg_d;
         wdata_q  <= wdata_d;
         st_q     <= st_d;
         stdata_q <= stdata_d;
      end
   end

   assign bus.md_ready            = fifo_ready;
   assign bus.md_pending          = fifo_pending;
   assign bus.ctrl_writeEnable    = we_q;
   assign bus.ctrl_writeReg       = wreg_q;
   assign bus.data_writeReg       = wdata_q;
   assign bus.ctrl_writeStatus    = st_q;
   assign bus.data_writeStatusReg = stdata_q;

`ifdef STAGE_WRITE_PERF_EN
   logic [31:0] perf_retired_q, perf_md_stall_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_retired_q  <= '0;
         perf_md_stall_q <= '0;
      end else begin
         if (we_d | st_d) perf_retired_q <= perf_retired_q + 32'd1;
         if (bus.md_valid & ~fifo_ready) perf_md_stall_q <= perf_md_stall_q + 32'd1;
      end
   end

   assign bus.perf_retired  = perf_retired_q;
   assign bus.perf_md_stall = perf_md_stall_q;
`endif

endmodule

// File: tb/tb_stage_write_arbiter.sv
// Directed bench for stage_write_arbiter: pipeline decode, md fall-through, backpressure,
// exception pairing and reset with queued entries.
module tb_stage_write_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_total = 0;
   int   n_pass  = 0;
   logic [31:0] exp_pend;
   logic [31:0] drain_pend [5];

   always #5 clock = ~clock;

   stage_write_arbiter_if #(.DATA_W(32), .REG_AW(5)) bus ();

   stage_write_arbiter #(
      .DATA_W(32), .REG_AW(5), .MD_DEPTH(4), .STATUS_REG(30), .LINK_REG(31)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_pipe();
      bus.in_valid   = 1'b0;
      bus.opcode     = 5'd0;
      bus.ALU_op     = 5'd0;
      bus.rd         = 5'd0;
      bus.o_in       = 32'd0;
      bus.d_in       = 32'd0;
      bus.pc_plus_4  = 32'd0;
      bus.pc_upper_5 = 5'd0;
      bus.target     = 27'd0;
      bus.exception  = 1'b0;
   endtask

   task automatic idle_md();
      bus.md_valid     = 1'b0;
      bus.md_rd        = 5'd0;
      bus.md_result    = 32'd0;
      bus.md_exception = 1'b0;
   endtask

   task automatic pipe(input logic [4:0] op, input logic [4:0] fn, input logic [4:0] rd,
                       input logic [31:0] o_val);
      idle_pipe();
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.ALU_op   = fn;
      bus.rd       = rd;
      bus.o_in     = o_val;
   endtask

   task automatic md_offer(input logic [4:0] rd, input logic [31:0] val, input logic exc);
      bus.md_valid     = 1'b1;
      bus.md_rd        = rd;
      bus.md_result    = val;
      bus.md_exception = exc;
   endtask

   initial begin
      drain_pend[0] = 32'h0000_001C;
      drain_pend[1] = 32'h0000_0038;
      drain_pend[2] = 32'h0000_0030;
      drain_pend[3] = 32'h0000_0020;
      drain_pend[4] = 32'h0000_0000;
      idle_pipe();
      idle_md();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_we", bus.ctrl_writeEnable, 1'b0);
      chk("rst_st", bus.ctrl_writeStatus, 1'b0);
      chk("rst_pend", bus.md_pending, 32'h0);
      chk("rst_ready", bus.md_ready, 1'b1);
      reset = 1'b0;

      // jal writes the link register with pc+4
      pipe(5'b00011, 5'd0, 5'd3, 32'hDEAD);
      bus.pc_plus_4 = 32'h104;
      tick();
      chk("jal_we", bus.ctrl_writeEnable, 1'b1);
      chk("jal_reg", bus.ctrl_writeReg, 5'd31);
      chk("jal_data", bus.data_writeReg, 32'h104);
      chk("jal_st", bus.ctrl_writeStatus, 1'b0);

      pipe(5'b00000, 5'b00000, 5'd0, 32'd5);
      tick();
      chk("r0_we", bus.ctrl_writeEnable, 1'b0);
      chk("r0_st", bus.ctrl_writeStatus, 1'b0);

      pipe(5'b01000, 5'd0, 5'd9, 32'h11);
      bus.d_in = 32'hCAFE;
      tick();
      chk("lw_reg", bus.ctrl_writeReg, 5'd9);
      chk("lw_data", bus.data_writeReg, 32'hCAFE);

      pipe(5'b00101, 5'd0, 5'd5, 32'h7FFF_FFFF);
      bus.exception = 1'b1;
      tick();
      chk("addi_exc_we", bus.ctrl_writeEnable, 1'b1);
      chk("addi_exc_reg", bus.ctrl_writeReg, 5'd5);
      chk("addi_exc_data", bus.data_writeReg, 32'h7FFF_FFFF);
      chk("addi_exc_st", bus.ctrl_writeStatus, 1'b1);
      chk("addi_exc_sdata", bus.data_writeStatusReg, 32'h1);

      pipe(5'b10101, 5'd0, 5'd0, 32'd0);
      bus.target = 27'h123;
      tick();
      chk("setx_we", bus.ctrl_writeEnable, 1'b0);
      chk("setx_st", bus.ctrl_writeStatus, 1'b1);
      chk("setx_sdata", bus.data_writeStatusReg, 32'h0000_0123);

      pipe(5'b10101, 5'd0, 5'd0, 32'd0);
      bus.pc_upper_5 = 5'h1F;
      bus.target     = 27'h1;
      tick();
      chk("setx_hi_sdata", bus.data_writeStatusReg, 32'hF800_0001);

      pipe(5'b00000, 5'b00110, 5'd4, 32'h55);
      tick();
      chk("mul_we", bus.ctrl_writeEnable, 1'b0);
      chk("mul_st", bus.ctrl_writeStatus, 1'b0);

      // md fall-through with an idle pipeline
      idle_pipe();
      md_offer(5'd7, 32'd42, 1'b0);
      chk("ft_ready", bus.md_ready, 1'b1);
      tick();
      idle_md();
      chk("ft_we", bus.ctrl_writeEnable, 1'b1);
      chk("ft_reg", bus.ctrl_writeReg, 5'd7);
      chk("ft_data", bus.data_writeReg, 32'd42);
      chk("ft_pend", bus.md_pending, 32'h0);
      tick();
      chk("ft_once", bus.ctrl_writeEnable, 1'b0);
      chk("ft_pend2", bus.md_pending, 32'h0);

      md_offer(5'd0, 32'd77, 1'b0);
      tick();
      idle_md();
      chk("mdr0_we", bus.ctrl_writeEnable, 1'b0);
      chk("mdr0_st", bus.ctrl_writeStatus, 1'b0);

      md_offer(5'd0, 32'd77, 1'b1);
      tick();
      idle_md();
      chk("mdr0x_we", bus.ctrl_writeEnable, 1'b0);
      chk("mdr0x_st", bus.ctrl_writeStatus, 1'b1);
      chk("mdr0x_sdata", bus.data_writeStatusReg, 32'h1);

      // five ALU writes block md offers rd=1..5; FIFO fills at four
      exp_pend = 32'h0;
      for (int i = 1; i <= 5; i++) begin
         pipe(5'b00000, 5'b00000, 5'd20, 32'(i * 100));
         md_offer(5'(i), 32'h100 + 32'(i), 1'b0);
         chk("bp_ready", bus.md_ready, (i <= 4) ? 32'h1 : 32'h0);
         tick();
         if (i <= 4) exp_pend = exp_pend | (32'h1 << i);
         chk("bp_we", bus.ctrl_writeEnable, 1'b1);
         chk("bp_reg", bus.ctrl_writeReg, 5'd20);
         chk("bp_data", bus.data_writeReg, 32'(i * 100));
         chk("bp_pend", bus.md_pending, exp_pend);
      end
      chk("bp_pend_full", bus.md_pending, 32'h1E);
      idle_pipe();
      for (int t = 1; t <= 5; t++) begin
         if (t == 1) chk("drain_ready0", bus.md_ready, 1'b0);
         if (t == 2) chk("drain_ready1", bus.md_ready, 1'b1);
         tick();
         if (t == 2) idle_md();
         chk("drain_we", bus.ctrl_writeEnable, 1'b1);
         chk("drain_reg", bus.ctrl_writeReg, 5'(t));
         chk("drain_data", bus.data_writeReg, 32'h100 + 32'(t));
         chk("drain_pend", bus.md_pending, drain_pend[t-1]);
      end
      tick();
      chk("drain_end_we", bus.ctrl_writeEnable, 1'b0);

      // md exception held while setx owns the status port
      pipe(5'b10101, 5'd0, 5'd0, 32'd0);
      bus.target = 27'h55;
      md_offer(5'd12, 32'h99, 1'b1);
      tick();
      idle_pipe();
      idle_md();
      chk("mdx_hold_we", bus.ctrl_writeEnable, 1'b0);
      chk("mdx_hold_sdata", bus.data_writeStatusReg, 32'h55);
      chk("mdx_hold_pend", bus.md_pending, 32'h4000_1000);
      tick();
      chk("mdx_we", bus.ctrl_writeEnable, 1'b1);
      chk("mdx_reg", bus.ctrl_writeReg, 5'd12);
      chk("mdx_data", bus.data_writeReg, 32'h99);
      chk("mdx_st", bus.ctrl_writeStatus, 1'b1);
      chk("mdx_sdata", bus.data_writeStatusReg, 32'h1);
      chk("mdx_pend", bus.md_pending, 32'h0);

      // md exception held while an addi owns only the data port
      pipe(5'b00101, 5'd0, 5'd6, 32'h66);
      md_offer(5'd13, 32'h77, 1'b1);
      tick();
      idle_pipe();
      idle_md();
      chk("mdxd_hold_reg", bus.ctrl_writeReg, 5'd6);
      chk("mdxd_hold_st", bus.ctrl_writeStatus, 1'b0);
      tick();
      chk("mdxd_reg", bus.ctrl_writeReg, 5'd13);
      chk("mdxd_st", bus.ctrl_writeStatus, 1'b1);

      // reset with three queued entries
      for (int i = 1; i <= 3; i++) begin
         pipe(5'b00000, 5'b00001, 5'd20, 32'h1);
         md_offer(5'(i), 32'(i), 1'b0);
         tick();
      end
      chk("pre_rst_pend", bus.md_pending, 32'h0E);
      idle_pipe();
      idle_md();
      #1;
      reset = 1'b1;
      #1;
      chk("arst_we", bus.ctrl_writeEnable, 1'b0);
      chk("arst_pend", bus.md_pending, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_we", bus.ctrl_writeEnable, 1'b0);
      chk("post_rst_st", bus.ctrl_writeStatus, 1'b0);
      chk("post_rst_pend", bus.md_pending, 32'h0);
      chk("post_rst_ready", bus.md_ready, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/stage_write_arbiter.md
Name: stage_write_arbiter

Overview:
- Registered writeback stage and sole owner of the regfile data write port and the rstatus write port.
- Merges two result sources onto those ports:
  - in-order pipeline results (ALU, addi, lw, jal, setx, exception status);
  - out-of-order results from the multi-cycle multdiv unit.
- Multdiv results that lose arbitration wait in a small FIFO.
- Exports a pending-destination mask so decode can stall on hazards against queued multdiv results.

Parameters:
- DATA_W, 32, regfile and status data width
- REG_AW, 5, register address width
- MD_DEPTH, 4, multdiv result FIFO depth; power of two, >=2
- STATUS_REG, 30, rstatus index, used only for the pending mask
- LINK_REG, 31, jal destination

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  a MEM/WB instruction is present this cycle
- opcode  in  5  instruction opcode
- ALU_op  in  5  R-type function field
- rd  in  REG_AW  destination register
- o_in  in  DATA_W  ALU result
- d_in  in  DATA_W  q_dmem load data
- pc_plus_4  in  DATA_W  link value
- pc_upper_5  in  5  PC[31:27]
- target  in  27  setx immediate
- exception  in  1  ALU overflow
- md_valid  in  1  multdiv result offered
- md_ready  out  1  FIFO can accept
- md_rd  in  REG_AW  multdiv destination
- md_result  in  DATA_W  multdiv value
- md_exception  in  1  multdiv overflow / divide-by-zero
- ctrl_writeEnable  out  1  regfile write strobe
- ctrl_writeReg  out  REG_AW  regfile address
- data_writeReg  out  DATA_W  regfile data
- ctrl_writeStatus  out  1  rstatus write strobe
- data_writeStatusReg  out  DATA_W  rstatus data
- md_pending  out  2**REG_AW  bit i set while a queued or just-accepted md result targets register i

Behaviour:
- All outputs are registered. Reset clears all outputs, the FIFO and the pointers to 0. Reset mid-operation discards queued results and must not produce write strobes.
- Decode, qualified by in_valid:
  - rtype = opcode 00000
  - addi 00101, lw 01000, jal 00011, setx 10101
  - mul = rtype & ALU_op 00110; div = rtype & ALU_op 00111
- Pipeline register write (p_wr): rtype excluding mul/div, or addi, lw, jal.
  - Address: LINK_REG if jal, else rd.
  - Data: pc_plus_4 if jal; d_in if lw; else o_in.
  - Address 0 clears p_wr.
- Pipeline status write (p_st):
  - add, sub or addi with exception=1 writes {0…,1};
  - setx writes {pc_upper_5,target}.
  - Non-exception add/sub/addi do not write status.
- mul/div in the pipeline write nothing here; their results arrive on the md channel.
- md_ready = (count < MD_DEPTH), evaluated on the current count. A push is accepted when md_valid & md_ready. When full, md_ready is 0 even if a pop occurs that cycle.
- Candidate md entry: the FIFO head if nonempty, else the incoming accepted md entry (fall-through, zero added latency).
- Each cycle, pipeline wins:
  - If p_wr or p_st is set, drive the pipeline write(s) on the next edge.
  - The md candidate retires only if its needed ports are free:
    - the data port when md_rd != 0;
    - additionally the status port (data 1) when md_exception=1.
  - An exception entry retires both writes in the same cycle or neither.
  - md_rd=0 without an exception retires silently with no strobe.
- A retired fall-through entry is not stored. A non-retired incoming entry is pushed. Simultaneous push and pop at partial occupancy keeps count unchanged.
- Write latency is one clock from the input cycle for both sources. Strobes are high for exactly one cycle per write.
- md_pending: OR over valid FIFO entries of onehot(md_rd), plus onehot(STATUS_REG) for exception entries; bit 0 is never set. The mask is registered and updates with the FIFO.
- Pointers are log2(MD_DEPTH)+1 bits wide; wrap is modulo 2·MD_DEPTH.

Optional Feature:
- Macro: STAGE_WRITE_PERF_EN.
- Defined:
  - adds outputs perf_retired (32b), incremented once per cycle with any write strobe;
  - adds perf_md_stall (32b), incremented each cycle md_valid & ~md_ready;
  - both reset to 0, wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package wb_pkg:
  - opcode and ALU_op localparams (OP_RTYPE, OP_ADDI, OP_LW, OP_JAL, OP_SETX, ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV);
  - md entry struct {rd, result, exception}.
- One natural sub-module, md_result_fifo: synchronous FIFO with count and per-entry valid for the mask.
- Decode and arbitration stay in the top.

Test Plan:
- Reset with FIFO holding 3 entries → next cycle all strobes 0, md_pending=0, md_ready=1.
- in_valid jal, pc_plus_4=0x104 → one cycle later writeEnable=1, writeReg=31, data=0x104; rd=0 add → no strobe.
- addi with exception=1, rd=5 → both strobes: reg5=o_in, status=1; setx target=0x123 with pc_upper_5=0 → status=0x00000123, no data strobe.
- md_valid rd=7, result=42, no pipeline op → write r7=42 the next cycle, md_pending never shows bit 7.
- 5 consecutive ALU writes while md offers rd=1..5 each cycle (MD_DEPTH=4) → 4 queued, md_ready=0 on the 5th offer, pending mask=0x1E, then drain in order r1..r4 at one per cycle, then r5.
- md exception entry while pipeline issues setx → md entry held until status port free, then r_md and status=1 retire together.
